adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter: NIBBLES, 4, operand width in 4-bit nibbles; W = 4*NIBBLES.
REQ-002 SHALL have port: clk  input  1  the only clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has an operation pending.
REQ-005 SHALL have port: req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 SHALL have port: req0_a, req0_b  input  W  requester 0 operands.
REQ-007 SHALL have port: req0_cin  input  1  requester 0 carry-in.
REQ-008 SHALL have port: req1_valid, req1_ready, req1_a, req1_b, req1_cin, same directions, widths and meanings as for requester 0.
REQ-009 SHALL have port: rsp_valid  output  1  result available.
REQ-010 SHALL have port: rsp_ready  input  1  consumer takes result.
REQ-011 SHALL have port: rsp_id  output  1  requester that owns the result.
REQ-012 SHALL have port: rsp_sum  output  W  sum bits.
REQ-013 SHALL have port: rsp_cout  output  1  final carry-out.
REQ-014 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL share one internal 4-bit adder stage ({c,s} = a_nib + b_nib + carry) between both requesters, processing one nibble per cycle, LSB nibble first.
REQ-016 SHALL implement FSM states IDLE, CALC, DONE.
REQ-017 IDLE: SHALL grant when any valid is high; one requester valid -> grant it; both valid -> grant the requester not granted last (round-robin).
REQ-018 SHALL drive readyN high combinationally only in IDLE and only for the granted requester; the other ready SHALL be low; both low in CALC and DONE.
REQ-019 On the handshake edge, SHALL latch the granted a, b, cin and id, clear the nibble index, clear the sum register, and go to CALC.
REQ-020 CALC: each cycle SHALL add nibble[idx] of a and b with the carry register, write s into sum nibble[idx], load c into the carry register, and increment idx.
REQ-021 CALC SHALL go to DONE on the edge where idx == NIBBLES-1, with the carry from that nibble as rsp_cout.
REQ-022 Latency: handshake in cycle 0 SHALL give rsp_valid high in cycle NIBBLES+1 (cycle 5 at default).
REQ-023 DONE: SHALL hold rsp_valid high and rsp_id, rsp_sum, rsp_cout stable until rsp_ready is high; on that edge SHALL update the last-grant pointer to rsp_id and go to IDLE.
REQ-024 SHALL accept no new operation in the DONE-to-IDLE cycle; next grant no earlier than the first cycle in IDLE.
REQ-025 SHALL treat a requester dropping valid before ready as having no effect; no state change.
REQ-026 SHALL ignore rsp_ready outside DONE.
REQ-027 Arithmetic SHALL be modulo 2^W with rsp_cout = bit W of a + b + cin.
REQ-028 Outside DONE, rsp_valid SHALL be 0; rsp_sum, rsp_cout, rsp_id MAY change and are don't-care.

Reset
REQ-029 On rst high at a rising edge, state SHALL go to IDLE; the last-grant pointer SHALL be set so requester 0 wins the first tie; idx, carry and sum SHALL be cleared.
REQ-030 During and after reset, before any grant: rsp_valid=0, busy=0, rsp_sum=0, rsp_cout=0, rsp_id=0; readyN follows REQ-017/018.
REQ-031 Reset in CALC or DONE SHALL discard the in-flight operation; no response issued.
REQ-032 rst SHALL take priority over every handshake in the same cycle.

Verification
REQ-033 Req0 0xFFFF + 0x0001, cin=0, rsp_ready=1 -> req0_ready in cycle 0; rsp_valid in cycle 5, rsp_sum=0x0000, rsp_cout=1, rsp_id=0.
REQ-034 Req1 0x1234 + 0x4321, cin=1 -> rsp_sum=0x5556, rsp_cout=0, rsp_id=1.
REQ-035 After reset, both valid held continuously with rsp_ready=1 -> grants alternate req0, req1, req0; each grant 6 cycles after the previous one.
REQ-036 rsp_ready=0 for 10 cycles in DONE -> rsp_valid and data stable for all 10 cycles, both readys low, busy=1; result consumed on the first rsp_ready=1 cycle.
REQ-037 rst asserted for one cycle in CALC (idx=2) -> next cycle IDLE, busy=0, rsp_valid never asserted for that operation; a following 0x0001 + 0x0001 op gives 0x0002.

Source files
------------

// File: rtl/adder_arbiter.sv
// Two-requester adder that time-shares one 4-bit adder stage, one nibble per cycle,
// with round-robin arbitration between requesters and a valid/ready result port.
module adder_arbiter #(
    parameter int NIBBLES = 4,
    localparam int W = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         busy
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             grant_id_s;
    logic             accept_s;
    logic             last_r;
    logic             id_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic [W-1:0]     sum_r;
    logic [W-1:0]     a_shift_s;
    logic [W-1:0]     b_shift_s;
    logic [4:0]       nib_sum_s;

    // Round-robin grant: on a tie the requester not served last wins.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant_id_s = ~last_r;
        end else if (req1_valid) begin
            grant_id_s = 1'b1;
        end else begin
            grant_id_s = 1'b0;
        end
        accept_s = (state_r == IDLE) && (req0_valid || req1_valid);
    end

    // Shared nibble adder fed by the nibble selected by idx_r.
    always_comb begin
        a_shift_s = a_r >> {idx_r, 2'b00};
        b_shift_s = b_r >> {idx_r, 2'b00};
        nib_sum_s = {1'b0, a_shift_s[3:0]} + {1'b0, b_shift_s[3:0]} + {4'b0000, carry_r};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = CALC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            CALC: begin
                if (idx_r == LAST_IDX) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = CALC;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode; readies are combinational so a grant completes in the same cycle.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state_r)
            IDLE: begin
                req0_ready = req0_valid && !grant_id_s;
                req1_ready = req1_valid && grant_id_s;
                busy       = 1'b0;
            end
            CALC: begin
                busy = 1'b1;
            end
            DONE: begin
                rsp_valid = 1'b1;
            end
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    // Operand capture, nibble-serial accumulation and last-grant tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r  <= 1'b1;
            id_r    <= 1'b0;
            carry_r <= 1'b0;
            idx_r   <= {IDX_W{1'b0}};
            a_r     <= {W{1'b0}};
            b_r     <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        id_r    <= grant_id_s;
                        a_r     <= grant_id_s ? req1_a : req0_a;
                        b_r     <= grant_id_s ? req1_b : req0_b;
                        carry_r <= grant_id_s ? req1_cin : req0_cin;
                        idx_r   <= {IDX_W{1'b0}};
                        sum_r   <= {W{1'b0}};
                    end
                end
                CALC: begin
                    sum_r[{idx_r, 2'b00} +: 4] <= nib_sum_s[3:0];
                    carry_r                    <= nib_sum_s[4];
                    idx_r                      <= idx_r + IDX_W'(1);
                end
                DONE: begin
                    if (rsp_ready) begin
                        last_r <= id_r;
                    end
                end
                default: begin
                    idx_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign rsp_id   = id_r;
    assign rsp_sum  = sum_r;
    assign rsp_cout = carry_r;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench: a cycle model predicts handshakes/results into a scoreboard queue
// that is popped and compared when the adder_arbiter delivers a response.
module tb_adder_arbiter;

    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    typedef struct packed {
        logic         id;
        logic         cout;
        logic [W-1:0] sum;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
    logic [W-1:0] rsp_sum;

    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb_q[$];
    int   m_state = 0;
    int   m_cnt = 0;
    logic m_last = 1'b1;
    int   hs_cyc = 0;
    bit   first_v = 1'b0;
    int   grant_ids[$];
    int   grant_cycs[$];
    logic [W-1:0] last_sum;
    logic last_cout, last_id;

    adder_arbiter #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model_add(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] full;
        exp_t e;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        e.id = id;
        e.cout = full[W];
        e.sum = full[W-1:0];
        return e;
    endfunction

    // Reference model: compare this cycle's outputs, then advance to the next edge.
    always @(negedge clk) begin
        logic exp_r0, exp_r1, gid;
        exp_r0 = (m_state == 0) && req0_valid && (!req1_valid || m_last);
        exp_r1 = (m_state == 0) && req1_valid && (!req0_valid || !m_last);
        check("req0_ready", req0_ready, exp_r0);
        check("req1_ready", req1_ready, exp_r1);
        check("busy", busy, m_state != 0);
        check("rsp_valid", rsp_valid, m_state == 2);
        if (m_state == 2) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 32'd0, 32'd1);
            end else begin
                check("rsp_id", rsp_id, sb_q[0].id);
                check("rsp_sum", rsp_sum, sb_q[0].sum);
                check("rsp_cout", rsp_cout, sb_q[0].cout);
            end
        end
        if (rst) begin
            sb_q.delete();
            m_state = 0;
            m_last = 1'b1;
            first_v = 1'b0;
        end else begin
            case (m_state)
                0: if (req0_valid || req1_valid) begin
                    gid = exp_r1;
                    sb_q.push_back(gid ? model_add(1'b1, req1_a, req1_b, req1_cin)
                                       : model_add(1'b0, req0_a, req0_b, req0_cin));
                    grant_ids.push_back(int'(gid));
                    grant_cycs.push_back(cyc);
                    hs_cyc = cyc;
                    m_cnt = 0;
                    m_state = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == NIBBLES) begin
                        m_state = 2;
                        first_v = 1'b1;
                    end
                end
                2: begin
                    if (first_v) begin
                        check("latency", cyc - hs_cyc, NIBBLES + 1);
                        first_v = 1'b0;
                    end
                    if (rsp_ready) begin
                        last_sum = rsp_sum;
                        last_cout = rsp_cout;
                        last_id = rsp_id;
                        if (sb_q.size() > 0) begin
                            m_last = sb_q[0].id;
                            void'(sb_q.pop_front());
                        end
                        m_state = 0;
                    end
                end
                default: m_state = 0;
            endcase
        end
    end

    task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bit got;
        got = 1'b0;
        if (id) begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("hs_timeout", got, 1'b1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (m_state == 0 && sb_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_timeout", done, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        rsp_ready = 1'b1;
        do_reset();
        @(negedge clk);
        check("rst_sum", rsp_sum, 16'h0000);
        check("rst_cout", rsp_cout, 1'b0);
        check("rst_id", rsp_id, 1'b0);
        @(posedge clk);
        #1;

        // Carry ripples through every nibble.
        run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        wait_idle();
        check("r033_sum", last_sum, 16'h0000);
        check("r033_cout", last_cout, 1'b1);
        check("r033_id", last_id, 1'b0);

        run_op(1'b1, 16'h1234, 16'h4321, 1'b1);
        wait_idle();
        check("r034_sum", last_sum, 16'h5556);
        check("r034_cout", last_cout, 1'b0);
        check("r034_id", last_id, 1'b1);

        // Both requesters held valid: grants must alternate every 6 cycles.
        do_reset();
        grant_ids.delete();
        grant_cycs.delete();
        req0_a = 16'h0101; req0_b = 16'h0202; req0_cin = 1'b0;
        req1_a = 16'h1000; req1_b = 16'h2000; req1_cin = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (grant_ids.size() >= 3) break;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        check("r035_n", grant_ids.size() >= 3, 1'b1);
        if (grant_ids.size() >= 3) begin
            check("r035_g0", grant_ids[0], 0);
            check("r035_g1", grant_ids[1], 1);
            check("r035_g2", grant_ids[2], 0);
            check("r035_d1", grant_cycs[1] - grant_cycs[0], 6);
            check("r035_d2", grant_cycs[2] - grant_cycs[1], 6);
        end

        // Consumer stalls for 10 cycles in DONE while both requesters wait.
        rsp_ready = 1'b0;
        run_op(1'b0, 16'hABCD, 16'h1111, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("r036_valid", seen, 1'b1);
        @(posedge clk);
        #1;
        req0_a = 16'h0003; req0_b = 16'h0004; req0_cin = 1'b0;
        req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("r036_sum", rsp_sum, 16'hBCDF);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        check("r036_next_id", last_id, 1'b1);
        check("r036_next_cout", last_cout, 1'b1);

        // Reset mid-calculation discards the operation.
        run_op(1'b0, 16'h00FF, 16'h0F01, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("r037_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        run_op(1'b0, 16'h0001, 16'h0001, 1'b0);
        wait_idle();
        check("r037_sum", last_sum, 16'h0002);
        check("r037_cout", last_cout, 1'b0);

        // Random valids, operands and back-pressure, including valid dropped before ready.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a = W'($urandom); req0_b = W'($urandom); req0_cin = 1'($urandom_range(0, 1));
            req1_a = W'($urandom); req1_b = W'($urandom); req1_cin = 1'($urandom_range(0, 1));
            rsp_ready = 1'($urandom_range(0, 1));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
